// File: rtl/weight_pkg.sv
// Shared constants and FSM encoding for the weight register-file loader.
package weight_pkg;

    localparam int DATA_W       = 8;
    localparam int KERNEL_SIZE  = 25;
    localparam int NUM_BANKS    = 2;
    localparam int ADDR_W       = 6;
    localparam int WEIGHT_COUNT = KERNEL_SIZE * NUM_BANKS;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/weight_loader.sv
// Streams weight bytes into the 2x25 weight register file and tracks which banks hold a complete kernel.
module weight_loader
    import weight_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 load_all,
    input  logic                 bank_sel,
    input  logic                 abort,
    input  logic                 s_valid,
    input  logic [DATA_W-1:0]    s_data,
    output logic                 s_ready,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err_start,
    output logic [NUM_BANKS-1:0] bank_ready
);

    localparam logic [ADDR_W-1:0] KERNEL_A = ADDR_W'(KERNEL_SIZE);
    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(WEIGHT_COUNT - 1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_W-1:0]     addr;
    logic [ADDR_W-1:0]     end_addr;
    logic [ADDR_W-1:0]     base_addr;
    logic [ADDR_W-1:0]     start_end;
    logic [NUM_BANKS-1:0]  load_mask;
    logic [NUM_BANKS-1:0]  start_mask;
    logic                  start_ok;
    logic                  accept;
    logic                  last_beat;

    assign s_ready = (state == LOAD);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    // Abort outranks both a start in IDLE and a beat offered in the same cycle.
    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        accept     = 1'b0;
        last_beat  = 1'b0;
        base_addr  = load_all ? '0 : ADDR_W'(bank_sel) * KERNEL_A;
        start_end  = load_all ? LAST_A : base_addr + KERNEL_A - ADDR_W'(1);
        start_mask = load_all ? '1 : NUM_BANKS'(1) << bank_sel;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    start_ok   = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (s_valid) begin
                    accept    = 1'b1;
                    last_beat = (addr == end_addr);
                    if (last_beat) state_next = FLUSH;
                end
            end
            FLUSH:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            end_addr   <= '0;
            load_mask  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            err_start  <= 1'b0;
            bank_ready <= '0;
        end else begin
            state     <= state_next;
            wr_en     <= accept;
            err_start <= start && (state != IDLE);
            if (accept) begin
                wr_addr <= addr;
                wr_data <= s_data;
                if (!last_beat) addr <= addr + ADDR_W'(1);
            end
            if (start_ok) begin
                addr       <= base_addr;
                end_addr   <= start_end;
                load_mask  <= start_mask;
                bank_ready <= bank_ready & ~start_mask;
            end
            // Flags rise entering DONE, one cycle after the final write lands.
            if (state == FLUSH) bank_ready <= bank_ready | load_mask;
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: table of loads plus abort, busy-start and reset corner cases.
module tb_weight_loader;
    import weight_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 load_all = 1'b0;
    logic                 bank_sel = 1'b0;
    logic                 abort = 1'b0;
    logic                 s_valid = 1'b0;
    logic [DATA_W-1:0]    s_data = '0;
    logic                 s_ready;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic                 busy;
    logic                 done;
    logic                 err_start;
    logic [NUM_BANKS-1:0] bank_ready;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_seen = 0;
    int err_seen = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                due;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic              load_all;
        logic              bank_sel;
        logic [DATA_W-1:0] dstart;
        bit                gaps;
        int                count;
        logic [ADDR_W-1:0] exp_base;
        logic [1:0]        exp_ready_start;
        logic [1:0]        exp_ready_done;
    } vec_t;
    vec_t vecs[3];

    weight_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .load_all(load_all),
        .bank_sel(bank_sel), .abort(abort), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err_start(err_start), .bank_ready(bank_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Write monitor: every strobe must match the scoreboard head in the cycle it is due.
    always @(negedge clk) begin
        if (rst_n) begin
            bit exp_en;
            exp_en = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            if (wr_en || exp_en) begin
                checkOutput("wr_en", 32'(wr_en), 32'(exp_en));
                if (exp_en) begin
                    checkOutput("wr_addr", 32'(wr_addr), 32'(exp_q[0].addr));
                    checkOutput("wr_data", 32'(wr_data), 32'(exp_q[0].data));
                    void'(exp_q.pop_front());
                end
            end
            if (done) done_seen++;
            if (err_start) err_seen++;
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_s_ready"}, 32'(s_ready), 0);
        checkOutput({tag, "_wr_en"}, 32'(wr_en), 0);
        checkOutput({tag, "_wr_addr"}, 32'(wr_addr), 0);
        checkOutput({tag, "_wr_data"}, 32'(wr_data), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
        checkOutput({tag, "_err_start"}, 32'(err_start), 0);
        checkOutput({tag, "_bank_ready"}, 32'(bank_ready), 0);
    endtask

    task automatic startLoad(input vec_t v);
        start = 1'b1;
        load_all = v.load_all;
        bank_sel = v.bank_sel;
        applyStimulus();
        start = 1'b0;
        checkOutput("start_busy", 32'(busy), 1);
        checkOutput("start_s_ready", 32'(s_ready), 1);
        checkOutput("start_bank_ready", 32'(bank_ready), 32'(v.exp_ready_start));
    endtask

    task automatic driveBeat(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_t w;
        s_valid = 1'b1;
        s_data = d;
        w.addr = a;
        w.data = d;
        w.due = cyc + 1;
        exp_q.push_back(w);
        applyStimulus();
        s_valid = 1'b0;
    endtask

    task automatic runLoad(input vec_t v, input int err_at, input bit abort_flush);
        int d0 = done_seen;
        int e0 = err_seen;
        startLoad(v);
        for (int i = 0; i < v.count; i++) begin
            if (v.gaps && i > 0) begin
                s_valid = 1'b0;
                applyStimulus();
            end
            start = (i == err_at);
            driveBeat(v.exp_base + ADDR_W'(i), v.dstart + DATA_W'(i));
            start = 1'b0;
            if (i == err_at) checkOutput("err_start_pulse", 32'(err_start), 1);
            if (i == err_at + 1) checkOutput("err_start_drop", 32'(err_start), 0);
        end
        checkOutput("flush_s_ready", 32'(s_ready), 0);
        checkOutput("flush_done", 32'(done), 0);
        abort = abort_flush;
        applyStimulus();
        abort = 1'b0;
        checkOutput("done_pulse", 32'(done), 1);
        checkOutput("done_bank_ready", 32'(bank_ready), 32'(v.exp_ready_done));
        applyStimulus();
        checkOutput("idle_done", 32'(done), 0);
        checkOutput("idle_busy", 32'(busy), 0);
        checkOutput("done_count", 32'(done_seen - d0), 1);
        checkOutput("err_count", 32'(err_seen - e0), (err_at >= 0) ? 1 : 0);
        checkOutput("writes_drained", 32'(exp_q.size()), 0);
    endtask

    initial begin
        vec_t v;
        int d0;
        vecs[0] = '{load_all: 1'b0, bank_sel: 1'b0, dstart: 8'h01, gaps: 1'b0, count: 25,
                    exp_base: 6'd0, exp_ready_start: 2'b00, exp_ready_done: 2'b01};
        vecs[1] = '{load_all: 1'b1, bank_sel: 1'b0, dstart: 8'h80, gaps: 1'b1, count: 50,
                    exp_base: 6'd0, exp_ready_start: 2'b00, exp_ready_done: 2'b11};
        vecs[2] = '{load_all: 1'b0, bank_sel: 1'b1, dstart: 8'h40, gaps: 1'b0, count: 25,
                    exp_base: 6'd25, exp_ready_start: 2'b01, exp_ready_done: 2'b11};

        applyStimulus();
        applyStimulus();
        checkAllZero("reset");
        rst_n = 1'b1;
        applyStimulus();
        checkAllZero("post_reset");

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        applyStimulus();
        start = 1'b0;
        abort = 1'b0;
        checkOutput("start_abort_busy", 32'(busy), 0);
        checkOutput("start_abort_err", 32'(err_start), 0);

        foreach (vecs[k]) runLoad(vecs[k], -1, 1'b0);

        // start while busy after 10 beats, abort ignored in FLUSH
        v = vecs[0];
        v.dstart = 8'hC0;
        v.exp_ready_start = 2'b10;
        v.exp_ready_done = 2'b11;
        runLoad(v, 10, 1'b1);

        // abort after 12 beats of a bank-0 load
        d0 = done_seen;
        startLoad(v);
        for (int i = 0; i < 12; i++) driveBeat(ADDR_W'(i), 8'h20 + DATA_W'(i));
        abort = 1'b1;
        applyStimulus();
        abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_s_ready", 32'(s_ready), 0);
        applyStimulus();
        applyStimulus();
        checkOutput("abort_no_done", 32'(done_seen - d0), 0);
        checkOutput("abort_bank_ready", 32'(bank_ready), 2'b10);
        checkOutput("abort_writes_drained", 32'(exp_q.size()), 0);
        v.dstart = 8'h60;
        runLoad(v, -1, 1'b0);

        // asynchronous reset after 5 beats of a full load
        v = vecs[1];
        v.gaps = 1'b0;
        v.exp_ready_start = 2'b00;
        startLoad(v);
        for (int i = 0; i < 5; i++) driveBeat(ADDR_W'(i), 8'h10 + DATA_W'(i));
        s_valid = 1'b1;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        s_valid = 1'b0;
        checkAllZero("async_reset");
        exp_q.delete();
        applyStimulus();
        rst_n = 1'b1;
        applyStimulus();
        v.dstart = 8'h33;
        runLoad(v, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
